// File: rtl/adc_stream_emulator_pkg.sv
// Shared definitions for the ADC stream emulator.
//   FRAME_BITS : nominal serial frame length (lead zeros + sample)
//   MODE_*     : channel A waveform select encodings
//   state_t    : frame FSM states
package adc_emu_pkg;
  localparam int FRAME_BITS = 16;

  localparam logic [1:0] MODE_RAMP  = 2'b00;
  localparam logic [1:0] MODE_TRI   = 2'b01;
  localparam logic [1:0] MODE_CONST = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;
endpackage

// File: rtl/adc_stream_emulator_if.sv
// Serial ADC link: frame select and clock from the controller, two data
// lines back from the converter (or its emulator).
//   master : controller side (drives CS/SCLK, reads SData_A/SData_B)
//   slave  : converter side (reads CS/SCLK, drives SData_A/SData_B)
interface adc_stream_emulator_if;
  logic CS;
  logic SCLK;
  logic SData_A;
  logic SData_B;

  modport master (output CS, SCLK, input SData_A, SData_B);
  modport slave  (input CS, SCLK, output SData_A, SData_B);
endinterface

// File: rtl/adc_stream_emulator_sync.sv
// sync_edge_detect: 2-flop synchronizer plus a history flop; rise/fall are
// decoded from the last two stages so they are one clock wide.
//   clk, rst : clock, async active-high reset
//   i_d      : asynchronous input pin
//   o_rise   : one-cycle pulse on a synchronized 0->1
//   o_fall   : one-cycle pulse on a synchronized 1->0
// RST_VAL is the line's idle level, so releasing reset does not fake an edge.
module sync_edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic r_s1, r_s2, r_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
      r_s3 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;
endmodule

// File: rtl/adc_stream_emulator.sv
// adc_stream_emulator: stands in for the dual-channel serial ADC. Answers
// CS/SCLK with 16-bit frames (lead zeros, then a 12-bit sample MSB first)
// carrying test waveforms: A = ramp/triangle/constant, B = square wave.
//   Main_CLK, Reset : system clock, async active-high reset
//   link            : CS/SCLK in, SData_A/SData_B out (slave modport)
//   Mode_A          : channel A waveform (00 ramp, 01 tri, 10 const, 11 ramp)
//   Const_Value     : channel A value in constant mode
//   Busy            : frame in progress
//   Frame_Count     : completed frames (CS rises), wrapping
//   Frame_Error     : one-cycle pulse when CS rises before the frame finished
module adc_stream_emulator
  import adc_emu_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int LEAD_ZEROS = 4,
  parameter int STEP_A     = 16,
  parameter int SQ_HALF    = 64
) (
  input  logic                  Main_CLK,
  input  logic                  Reset,
  adc_stream_emulator_if.slave  link,
  input  logic [1:0]            Mode_A,
  input  logic [DATA_WIDTH-1:0] Const_Value,
  output logic                  Busy,
  output logic [15:0]           Frame_Count,
  output logic                  Frame_Error
);
  localparam int FB  = LEAD_ZEROS + DATA_WIDTH;
  localparam int CW  = $clog2(FB);
  localparam int SQW = (SQ_HALF > 1) ? $clog2(SQ_HALF) : 1;
  localparam logic [DATA_WIDTH-1:0] MAXV = '1;
  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(STEP_A);

  logic w_cs_rise, w_cs_fall, w_sclk_fall;
  // SCLK rising edges carry no meaning for the responder.
  logic w_sclk_rise_unused;

  sync_edge_detect #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(Main_CLK), .rst(Reset), .i_d(link.CS),
    .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  sync_edge_detect #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(Main_CLK), .rst(Reset), .i_d(link.SCLK),
    .o_rise(w_sclk_rise_unused), .o_fall(w_sclk_fall)
  );

  state_t                r_state, w_next;
  logic [FB-1:0]         r_sh_a, r_sh_b;
  logic [CW-1:0]         r_cnt;
  logic                  r_busy;
  logic [15:0]           r_frame_count;
  logic [DATA_WIDTH-1:0] r_a;
  logic                  r_dir_dn;
  logic                  r_b;
  logic [SQW-1:0]        r_sq_cnt;
  logic                  w_err;

  // CS rise ends the frame from any active state and overrides a same-cycle
  // SCLK fall.
  logic w_frame_end, w_frame_start, w_shift;
  assign w_frame_end   = w_cs_rise && (r_state != ST_IDLE);
  assign w_frame_start = w_cs_fall && (r_state == ST_IDLE);
  assign w_shift       = w_sclk_fall && (r_state != ST_IDLE);

  always_ff @(posedge Main_CLK or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_cs_fall) w_next = ST_SHIFT;
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_next = ST_IDLE;
          w_err  = 1'b1;
        end else if (w_sclk_fall && r_cnt == CW'(1)) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE:  if (w_cs_rise) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Triangle next value: saturate at each endpoint and flip direction there,
  // so each endpoint is emitted exactly once.
  logic [DATA_WIDTH:0]   w_up;
  logic [DATA_WIDTH-1:0] w_tri_next;
  logic                  w_tri_dn;
  always_comb begin
    w_up       = {1'b0, r_a} + {1'b0, STEP};
    w_tri_next = r_a;
    w_tri_dn   = r_dir_dn;
    if (!r_dir_dn) begin
      if (w_up >= {1'b0, MAXV}) begin
        w_tri_next = MAXV;
        w_tri_dn   = 1'b1;
      end else begin
        w_tri_next = w_up[DATA_WIDTH-1:0];
      end
    end else begin
      if (r_a <= STEP) begin
        w_tri_next = '0;
        w_tri_dn   = 1'b0;
      end else begin
        w_tri_next = r_a - STEP;
      end
    end
  end

  always_ff @(posedge Main_CLK or posedge Reset) begin
    if (Reset) begin
      r_sh_a        <= '0;
      r_sh_b        <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_frame_count <= '0;
      r_a           <= '0;
      r_dir_dn      <= 1'b0;
      r_b           <= 1'b0;
      r_sq_cnt      <= '0;
    end else if (w_frame_end) begin
      r_sh_a        <= '0;
      r_sh_b        <= '0;
      r_busy        <= 1'b0;
      r_frame_count <= r_frame_count + 16'd1;
      case (Mode_A)
        MODE_TRI: begin
          r_a      <= w_tri_next;
          r_dir_dn <= w_tri_dn;
        end
        MODE_CONST: r_a <= Const_Value;
        default:    r_a <= r_a + STEP;
      endcase
      if (r_sq_cnt == SQW'(SQ_HALF - 1)) begin
        r_sq_cnt <= '0;
        r_b      <= ~r_b;
      end else begin
        r_sq_cnt <= r_sq_cnt + SQW'(1);
      end
    end else if (w_frame_start) begin
      r_sh_a <= {{LEAD_ZEROS{1'b0}}, r_a};
      r_sh_b <= {{LEAD_ZEROS{1'b0}}, {DATA_WIDTH{r_b}}};
      r_cnt  <= CW'(FB - 1);
      r_busy <= 1'b1;
    end else if (w_shift) begin
      // Zeros shift in behind the data, so DONE naturally drives 0.
      r_sh_a <= {r_sh_a[FB-2:0], 1'b0};
      r_sh_b <= {r_sh_b[FB-2:0], 1'b0};
      if (r_state == ST_SHIFT) r_cnt <= r_cnt - CW'(1);
    end
  end

  assign link.SData_A = r_sh_a[FB-1];
  assign link.SData_B = r_sh_b[FB-1];
  assign Busy         = r_busy;
  assign Frame_Count  = r_frame_count;
  assign Frame_Error  = w_err;
endmodule
